flag_branch_unit: RTL

- Downstream consumer of the ALU zero-detect result (64-bit NOR-reduce `zero` flag) and the remaining ALU flags in the EX stage of the ARM-subset CPU.
- Holds the architectural NZCV flag register, updated by flag-setting instructions (ADDS/SUBS).
- Resolves B, CBZ and B.cond, and registers the branch decision into the EX/MEM boundary for the PC-select logic.
- Keeps a saturating taken-branch counter for debug.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/flag_branch_unit_if.sv | 32 +++
 rtl/flag_branch_unit_cond_eval.sv | 47 ++++
 rtl/flag_branch_unit.sv | 83 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch op encoding, ARM condition codes, NZCV bit indices.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_UNCOND = 2'b01,
    BR_CBZ    = 2'b10,
    BR_COND   = 2'b11
  } br_op_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage bundle between the pipeline (master) and flag_branch_unit (slave).
interface flag_branch_unit_if #(parameter int CNT_W = 16);
  logic             valid_in;
  logic             stall;
  logic             flush;
  logic             set_flags;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic [1:0]       br_op;
  logic [3:0]       cond;
  logic             cbz_zero;
  logic [3:0]       flags_q;
  logic             br_valid_q;
  logic             br_taken_q;
  logic [CNT_W-1:0] taken_count_q;

  modport master (
    output valid_in, stall, flush, set_flags,
    output alu_negative, alu_zero, alu_carry, alu_overflow,
    output br_op, cond, cbz_zero,
    input  flags_q, br_valid_q, br_taken_q, taken_count_q
  );

  modport slave (
    input  valid_in, stall, flush, set_flags,
    input  alu_negative, alu_zero, alu_carry, alu_overflow,
    input  br_op, cond, cbz_zero,
    output flags_q, br_valid_q, br_taken_q, taken_count_q
  );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// ARM condition evaluation against NZCV. FLAG_BRANCH_FULL_COND_EN enables the
// full condition set; otherwise only LT is recognised.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

`ifdef FLAG_BRANCH_FULL_COND_EN
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_HS: cond_true = c;
      COND_LO: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      default: cond_true = 1'b1; // AL (E) and F both mean always
    endcase
  end
`else
  logic unused_zc;
  assign unused_zc = z ^ c;

  always_comb begin
    cond_true = (cond == COND_LT) & (n != v);
  end
`endif

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage NZCV register, B/CBZ/B.cond resolution with a 1-cycle registered
// decision, and a saturating taken-branch counter. Optional: FLAG_BRANCH_FULL_COND_EN.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  flag_branch_unit_if.slave bus
);

  logic [3:0]       flags_q, flags_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  br_op_t op;
  logic   is_br, take, cond_true;

  assign op    = br_op_t'(bus.br_op);
  assign is_br = (op != BR_NONE);

  // Evaluated against the stored flags, so a same-cycle flag write is not seen.
  cond_eval u_cond_eval (
    .cond      (bus.cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  always_comb begin
    take = 1'b0;
    case (op)
      BR_UNCOND: take = 1'b1;
      BR_CBZ:    take = bus.cbz_zero;
      BR_COND:   take = cond_true;
      default:   take = 1'b0;
    endcase
  end

  always_comb begin
    flags_d    = flags_q;
    br_valid_d = br_valid_q;
    br_taken_d = br_taken_q;
    cnt_d      = cnt_q;
    if (bus.flush) begin
      br_valid_d = 1'b0;
      br_taken_d = 1'b0;
    end else if (!bus.stall) begin
      if (bus.valid_in) begin
        if (bus.set_flags)
          flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        br_valid_d = is_br;
        br_taken_d = is_br & take;
        if (is_br && take && !(&cnt_q))
          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        br_valid_d = 1'b0;
        br_taken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q    <= 4'b0000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.flags_q       = flags_q;
  assign bus.br_valid_q    = br_valid_q;
  assign bus.br_taken_q    = br_taken_q;
  assign bus.taken_count_q = cnt_q;

endmodule
